// File: rtl/upec_miter_monitor.sv
// Two-instance miter: compares channels of instance A (optionally delayed) against
// instance B and latches the first divergence into a sticky flag plus capture registers.
module upec_miter_monitor #(
    parameter int NumChannels  = 4,
    parameter int ChanWidth    = 32,
    parameter int DelayA       = 0,
    parameter int WarmupCycles = 2,
    parameter int CntWidth     = 16,
    localparam int IdxW        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             arm_i,
    input  logic                             clr_i,
    input  logic                             excl_i,
    input  logic [NumChannels-1:0]           chan_mask_i,
    input  logic [NumChannels*ChanWidth-1:0] a_i,
    input  logic [NumChannels*ChanWidth-1:0] b_i,
    output logic [1:0]                       state_o,
    output logic                             diverged_o,
    output logic [IdxW-1:0]                  div_chan_o,
    output logic [ChanWidth-1:0]             div_diff_o,
    output logic [CntWidth-1:0]              div_cycle_o
);

    localparam int Warm = (WarmupCycles > DelayA) ? WarmupCycles : DelayA;
    localparam logic [CntWidth-1:0] WarmLast = CntWidth'((Warm > 0) ? Warm - 1 : 0);

    // Handshake: none; arm_i/clr_i are level inputs sampled on each rising clk edge.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WARMUP   = 2'd1,
        S_MONITOR  = 2'd2,
        S_DIVERGED = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CntWidth-1:0]            cnt_q, cnt_d, cnt_inc;
    logic [IdxW-1:0]                chan_q, chan_d, first_idx;
    logic [ChanWidth-1:0]           diff_q, diff_d, first_diff;
    logic [CntWidth-1:0]            cyc_q, cyc_d;
    logic [NumChannels-1:0]         mis;
    logic [NumChannels*ChanWidth-1:0] a_d;

    // Delay line on A keeps shifting regardless of state; only reset clears it.
    generate
        if (DelayA == 0) begin : g_nodly
            assign a_d = a_i;
        end else begin : g_dly
            logic [NumChannels*ChanWidth-1:0] stage_q [DelayA];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DelayA; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= a_i;
                    for (int i = 1; i < DelayA; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign a_d = stage_q[DelayA-1];
        end
    endgenerate

    always_comb begin
        mis        = '0;
        first_idx  = '0;
        first_diff = '0;
        for (int k = 0; k < NumChannels; k++) begin
            mis[k] = chan_mask_i[k] & ~excl_i &
                     (a_d[k*ChanWidth +: ChanWidth] != b_i[k*ChanWidth +: ChanWidth]);
        end
        // Walk downward so the lowest mismatching channel is the one left standing.
        for (int k = NumChannels - 1; k >= 0; k--) begin
            if (mis[k]) begin
                first_idx  = IdxW'(k);
                first_diff = a_d[k*ChanWidth +: ChanWidth] ^ b_i[k*ChanWidth +: ChanWidth];
            end
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        diff_d  = diff_q;
        cyc_d   = cyc_q;
        unique case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    cnt_d   = '0;
                    state_d = (Warm == 0) ? S_MONITOR : S_WARMUP;
                end
            end
            S_WARMUP: begin
                cnt_d = cnt_inc;
                if (cnt_q == WarmLast) state_d = S_MONITOR;
            end
            S_MONITOR: begin
                cnt_d = cnt_inc;
                if (|mis) begin
                    state_d = S_DIVERGED;
                    chan_d  = first_idx;
                    diff_d  = first_diff;
                    cyc_d   = cnt_q;
                end
            end
            S_DIVERGED: begin
            end
            default: state_d = S_IDLE;
        endcase
        if (clr_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            chan_d  = '0;
            diff_d  = '0;
            cyc_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
            diff_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
            diff_q  <= diff_d;
            cyc_q   <= cyc_d;
        end
    end

    assign state_o     = state_q;
    assign diverged_o  = (state_q == S_DIVERGED);
    assign div_chan_o  = chan_q;
    assign div_diff_o  = diff_q;
    assign div_cycle_o = cyc_q;

endmodule

// File: tb/tb_upec_miter_monitor.sv
// Bench for upec_miter_monitor: two instances (default and skewed/short-counter)
// checked every cycle against a cycles-since-arm reference model.
module tb_upec_miter_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam int CW[2]   = '{32, 8};
    localparam int DL[2]   = '{0, 3};
    localparam int WM[2]   = '{2, 5};
    localparam int CMAX[2] = '{65535, 15};

    logic         arm0 = 0, clr0 = 0, excl0 = 0;
    logic [3:0]   mask0 = 4'hF;
    logic [127:0] a0 = '0, b0 = '0;
    logic [1:0]   st0, ch0;
    logic         dv0;
    logic [31:0]  df0;
    logic [15:0]  cy0;

    logic         arm1 = 0, clr1 = 0, excl1 = 0;
    logic [3:0]   mask1 = 4'hF;
    logic [31:0]  a1 = '0, b1 = '0;
    logic [1:0]   st1, ch1;
    logic         dv1;
    logic [7:0]   df1;
    logic [3:0]   cy1;

    upec_miter_monitor u0 (
        .clk_i(clk), .rst_ni(rst_n), .arm_i(arm0), .clr_i(clr0), .excl_i(excl0),
        .chan_mask_i(mask0), .a_i(a0), .b_i(b0), .state_o(st0), .diverged_o(dv0),
        .div_chan_o(ch0), .div_diff_o(df0), .div_cycle_o(cy0)
    );

    upec_miter_monitor #(
        .NumChannels(4), .ChanWidth(8), .DelayA(3), .WarmupCycles(5), .CntWidth(4)
    ) u1 (
        .clk_i(clk), .rst_ni(rst_n), .arm_i(arm1), .clr_i(clr1), .excl_i(excl1),
        .chan_mask_i(mask1), .a_i(a1), .b_i(b1), .state_o(st1), .diverged_o(dv1),
        .div_chan_o(ch1), .div_diff_o(df1), .div_cycle_o(cy1)
    );

    int total = 0;
    int bad = 0;

    // Reference model: "active" plus cycles since arm, a history array for the A skew.
    bit           m_active[2];
    bit           m_div[2];
    int           m_since[2];
    int           m_chan[2];
    logic [31:0]  m_diff[2];
    int           m_cyc[2];
    logic [127:0] hist[2][16];

    function automatic logic [31:0] chan(input logic [127:0] v, input int k, input int w);
        logic [127:0] m;
        m = (128'd1 << w) - 128'd1;
        return 32'((v >> (k * w)) & m);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_div[i] = 0; m_since[i] = 0;
            m_chan[i] = 0; m_diff[i] = '0; m_cyc[i] = 0;
            for (int s = 0; s < 16; s++) hist[i][s] = '0;
        end
    endtask

    task automatic model_step(input int i, input logic arm, input logic clr, input logic excl,
                              input logic [3:0] mask, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] ad;
        int first;
        ad = (DL[i] == 0) ? a : hist[i][DL[i]-1];
        first = -1;
        for (int k = 3; k >= 0; k--)
            if (mask[k] && !excl && chan(ad, k, CW[i]) != chan(b, k, CW[i])) first = k;
        if (clr) begin
            m_active[i] = 0; m_div[i] = 0; m_since[i] = 0;
            m_chan[i] = 0; m_diff[i] = '0; m_cyc[i] = 0;
        end else if (m_active[i]) begin
            if (m_since[i] >= WM[i] && first >= 0) begin
                m_div[i]    = 1;
                m_active[i] = 0;
                m_chan[i]   = first;
                m_diff[i]   = chan(ad, first, CW[i]) ^ chan(b, first, CW[i]);
                m_cyc[i]    = (m_since[i] > CMAX[i]) ? CMAX[i] : m_since[i];
            end
            m_since[i]++;
        end else if (!m_div[i] && arm) begin
            m_active[i] = 1;
            m_since[i]  = 0;
        end
        for (int s = 15; s > 0; s--) hist[i][s] = hist[i][s-1];
        hist[i][0] = a;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0, arm0, clr0, excl0, mask0, a0, b0);
            model_step(1, arm1, clr1, excl1, mask1, {96'd0, a1}, {96'd0, b1});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int i, input string tag);
        logic [31:0] exp_st;
        exp_st = m_div[i] ? 32'd3 : (m_active[i] ? ((m_since[i] < WM[i]) ? 32'd1 : 32'd2) : 32'd0);
        if (i == 0) begin
            chk({tag, "/u0.state"}, 32'(st0), exp_st);
            chk({tag, "/u0.div"},   32'(dv0), 32'(m_div[0]));
            chk({tag, "/u0.chan"},  32'(ch0), 32'(m_chan[0]));
            chk({tag, "/u0.diff"},  df0,      m_diff[0]);
            chk({tag, "/u0.cycle"}, 32'(cy0), 32'(m_cyc[0]));
        end else begin
            chk({tag, "/u1.state"}, 32'(st1), exp_st);
            chk({tag, "/u1.div"},   32'(dv1), 32'(m_div[1]));
            chk({tag, "/u1.chan"},  32'(ch1), 32'(m_chan[1]));
            chk({tag, "/u1.diff"},  32'(df1), m_diff[1]);
            chk({tag, "/u1.cycle"}, 32'(cy1), 32'(m_cyc[1]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_all(0, tag);
        check_all(1, tag);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [31:0] ah[$];

    task automatic push_skew(input int skew);
        a1 = $urandom;
        ah.push_back(a1);
        b1 = ah[ah.size() - 1 - skew];
    endtask

    initial begin
        model_reset();
        #12;
        check_all(0, "reset");
        check_all(1, "reset");
        rst_n = 1'b1;
        tick("post_reset");

        // Arm, equal random data, then ch2 bit5 differs at cnt==40.
        arm0 = 1; a0 = rnd128(); b0 = a0;
        tick("arm0");
        arm0 = 0;
        for (int c = 0; c < 40; c++) begin
            a0 = rnd128(); b0 = a0;
            tick("equal0");
        end
        a0 = rnd128(); b0 = a0 ^ (128'h20 << 64);
        tick("ch2_bit5");
        chk("t1.div", 32'(dv0), 32'd1);
        chk("t1.chan", 32'(ch0), 32'd2);
        chk("t1.diff", df0, 32'h20);
        chk("t1.cycle", 32'(cy0), 32'd40);
        chk("t1.state", 32'(st0), 32'd3);
        a0 = rnd128(); b0 = a0 ^ 128'h1;
        tick("later_ch0");
        chk("t1.sticky_chan", 32'(ch0), 32'd2);

        // clr with arm in DIVERGED: clear wins.
        clr0 = 1; arm0 = 1;
        tick("clr_arm0");
        clr0 = 0; arm0 = 0;
        chk("t2.idle", 32'(st0), 32'd0);
        chk("t2.cycle0", 32'(cy0), 32'd0);

        // Same-cycle mismatch on ch1 and ch3.
        a0 = '0; b0 = '0; arm0 = 1;
        tick("arm0b");
        arm0 = 0;
        tick("warm0a");
        tick("warm0b");
        b0 = (128'h5 << 32) | (128'h9 << 96);
        tick("ch1_ch3");
        chk("t2.chan", 32'(ch0), 32'd1);
        chk("t2.diff", df0, 32'h5);
        b0 = 128'h3;
        tick("later_ch0b");
        chk("t2.sticky_diff", df0, 32'h5);

        // Masked ch2 plus excluded ch0, then drop the exclusion.
        clr0 = 1; tick("clr0c"); clr0 = 0;
        b0 = '0; arm0 = 1; tick("arm0c"); arm0 = 0;
        mask0 = 4'b1011; excl0 = 1;
        b0 = (128'hFF << 64) | 128'h7;
        for (int c = 0; c < 6; c++) tick("mask_excl");
        chk("t3.nodiv", 32'(dv0), 32'd0);
        excl0 = 0;
        tick("drop_excl");
        chk("t3.div", 32'(dv0), 32'd1);
        chk("t3.chan", 32'(ch0), 32'd0);
        chk("t3.diff", df0, 32'h7);
        mask0 = 4'hF; b0 = '0;

        // Randomized control and data on u0.
        for (int c = 0; c < 300; c++) begin
            arm0  = ($urandom_range(0, 7) == 0);
            clr0  = ($urandom_range(0, 39) == 0);
            excl0 = ($urandom_range(0, 3) == 0);
            mask0 = 4'($urandom_range(0, 15));
            a0 = rnd128(); b0 = a0;
            if ($urandom_range(0, 9) == 0) b0[$urandom_range(0, 127)] ^= 1'b1;
            tick("rand0");
        end
        arm0 = 0; clr0 = 0; excl0 = 0; mask0 = 4'hF;

        // u1: DelayA=3 with matching external skew, then skew of 2.
        for (int s = 0; s < 8; s++) ah.push_back('0);
        arm1 = 1; push_skew(3);
        tick("arm1");
        arm1 = 0;
        for (int c = 0; c < 200; c++) begin
            push_skew(3);
            tick("skew3");
        end
        chk("t4.nodiv", 32'(dv1), 32'd0);
        for (int c = 0; c < 10; c++) begin
            push_skew(2);
            tick("skew2");
        end
        chk("t4.div", 32'(dv1), 32'd1);
        chk("t4.cycle_sat", 32'(cy1), 32'hF);

        // Mismatch held through warm-up (Warm=5).
        a1 = '0; b1 = '0; clr1 = 1;
        for (int c = 0; c < 4; c++) tick("flush1");
        clr1 = 0;
        b1 = 32'h1; arm1 = 1;
        tick("arm1b");
        arm1 = 0;
        for (int c = 0; c < 5; c++) begin
            tick("warm1");
            chk("t5.nodiv", 32'(dv1), 32'd0);
        end
        tick("warm1_done");
        chk("t5.div", 32'(dv1), 32'd1);
        chk("t5.cycle", 32'(cy1), 32'd5);
        clr1 = 1; arm1 = 1;
        tick("clr_arm1");
        clr1 = 0; arm1 = 0;
        chk("t5.idle", 32'(st1), 32'd0);
        chk("t5.diff0", 32'(df1), 32'd0);

        // Divergence 20 cycles after arm saturates the 4-bit cycle capture.
        b1 = '0; arm1 = 1;
        tick("arm1c");
        arm1 = 0;
        for (int c = 0; c < 20; c++) tick("run1");
        b1 = 32'h0500;
        tick("late_mis");
        chk("t6.cycle", 32'(cy1), 32'hF);
        chk("t6.chan", 32'(ch1), 32'd1);
        chk("t6.diff", 32'(df1), 32'h5);

        // Asynchronous reset while monitoring.
        clr1 = 1; b1 = '0; tick("clr1d"); clr1 = 0;
        arm1 = 1; tick("arm1d"); arm1 = 0;
        for (int c = 0; c < 7; c++) tick("mon1");
        chk("t7.monitor", 32'(st1), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_all(0, "async_rst");
        check_all(1, "async_rst");
        chk("t7.state", 32'(st1), 32'd0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) tick("after_rst");
        chk("t7.stay_idle", 32'(st1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
